ntt_bram_sched: RTL and testbench

- Sequences one in-place radix-2 NTT (DIF ordering, natural-order input) over a single 2048x36 coefficient BRAM.
- The BRAM has a registered-address read port and a write port.
- Generates read addresses, butterfly load/fire strobes, twiddle indices, and delayed write-back addresses with enables.
- Sits between the top-level NTT control FSM (start/done) and the BRAM plus butterfly datapath. It carries no coefficient data itself.

---
 rtl/ntt_bram_sched.sv | 111 +++++++++++
 tb/tb_ntt_bram_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ntt_bram_sched.sv
// ntt_bram_sched: address/strobe sequencer for an in-place radix-2 DIF NTT over one BRAM
module ntt_bram_sched #(
  parameter int LOGN   = 11,
  parameter int BF_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic [LOGN-1:0] rd_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr,
  output logic            wr_sel,
  output logic            bf_ld_a,
  output logic            bf_go,
  output logic [LOGN-2:0] tw_idx
);
  localparam int D = BF_LAT + 2;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;
  localparam logic [LOGN-1:0] TOP = LOGN'(LOGN - 1);
  logic [1:0] state_q, state_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [LOGN-2:0] j_q, j_d, tw_q, tw_d, tw;
  logic ph_q, ph_d, go_q, go_d, done_q, done_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [D-1:0] v_q, v_d, s_q, s_d;
  logic [LOGN-1:0] pa_q [D];
  logic [LOGN-1:0] pa_d [D];
  logic [LOGN-1:0] h, mask, jw, a, b;
  always_comb begin
    h = LOGN'(1) << (TOP - stage_q);
    mask = h - LOGN'(1);
    jw = {1'b0, j_q};
    a = ((jw & ~mask) << 1) | (jw & mask);
    b = a | h;
    tw = (j_q & mask[LOGN-2:0]) << stage_q;
    rd_addr = (state_q == ISSUE) ? (ph_q ? b : a) : '0;
    state_d = state_q;
    stage_d = stage_q;
    j_d = j_q;
    ph_d = ph_q;
    dcnt_d = dcnt_q;
    done_d = 1'b0;
    go_d = (state_q == ISSUE) && ph_q;
    tw_d = go_d ? tw : tw_q;
    // write-back pipeline: one slot per read, retimed by BF_LAT+2
    v_d = {v_q[D-2:0], state_q == ISSUE};
    s_d = {s_q[D-2:0], ph_q};
    pa_d[0] = rd_addr;
    for (int i = 1; i < D; i++) pa_d[i] = pa_q[i-1];
    if (state_q == IDLE && start && !done_q) begin
      state_d = ISSUE;
      stage_d = '0;
      j_d = '0;
      ph_d = 1'b0;
    end else if (state_q == ISSUE) begin
      ph_d = ~ph_q;
      if (ph_q) j_d = j_q + (LOGN-1)'(1);
      if (ph_q && &j_q) begin
        state_d = DRAIN;
        dcnt_d = '0;
      end
    end else if (state_q == DRAIN) begin
      dcnt_d = dcnt_q + 4'd1;
      if (dcnt_q == 4'(D - 1)) begin
        state_d = (stage_q == TOP) ? IDLE : ISSUE;
        done_d = (stage_q == TOP);
        stage_d = (stage_q == TOP) ? stage_q : stage_q + LOGN'(1);
        ph_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      j_q <= '0;
      ph_q <= 1'b0;
      dcnt_q <= '0;
      done_q <= 1'b0;
      go_q <= 1'b0;
      tw_q <= '0;
      v_q <= '0;
      s_q <= '0;
      for (int i = 0; i < D; i++) pa_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q <= j_d;
      ph_q <= ph_d;
      dcnt_q <= dcnt_d;
      done_q <= done_d;
      go_q <= go_d;
      tw_q <= tw_d;
      v_q <= v_d;
      s_q <= s_d;
      for (int i = 0; i < D; i++) pa_q[i] <= pa_d[i];
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign stage = stage_q;
  assign bf_ld_a = (state_q == ISSUE) && ph_q;
  assign bf_go = go_q;
  assign tw_idx = tw_q;
  assign wr_en = v_q[D-1];
  assign wr_sel = s_q[D-1];
  assign wr_addr = pa_q[D-1];
endmodule

// File: tb/tb_ntt_bram_sched.sv
// tb_ntt_bram_sched: cycle-accurate checks of a small and a full-size scheduler
module tb_ntt_bram_sched;
  logic clk = 1'b0, rst = 1'b1, start_s = 1'b0, start_b = 1'b0, use_big = 1'b0;
  always #5 clk = ~clk;
  logic busy_s, done_s, we_s, sel_s, ld_s, go_s;
  logic [2:0] stage_s, rd_s, wa_s;
  logic [1:0] tw_s;
  logic busy_b, done_b, we_b, sel_b, ld_b, go_b;
  logic [10:0] stage_b, rd_b, wa_b;
  logic [9:0] tw_b;
  ntt_bram_sched #(.LOGN(3), .BF_LAT(2)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .stage(stage_s),
    .rd_addr(rd_s), .wr_en(we_s), .wr_addr(wa_s), .wr_sel(sel_s), .bf_ld_a(ld_s),
    .bf_go(go_s), .tw_idx(tw_s));
  ntt_bram_sched u_big (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .stage(stage_b),
    .rd_addr(rd_b), .wr_en(we_b), .wr_addr(wa_b), .wr_sel(sel_b), .bf_ld_a(ld_b),
    .bf_go(go_b), .tw_idx(tw_b));
  logic [31:0] o_busy, o_done, o_we, o_sel, o_ld, o_go, o_stage, o_rd, o_wa, o_tw;
  assign o_busy  = use_big ? 32'(busy_b)  : 32'(busy_s);
  assign o_done  = use_big ? 32'(done_b)  : 32'(done_s);
  assign o_we    = use_big ? 32'(we_b)    : 32'(we_s);
  assign o_sel   = use_big ? 32'(sel_b)   : 32'(sel_s);
  assign o_ld    = use_big ? 32'(ld_b)    : 32'(ld_s);
  assign o_go    = use_big ? 32'(go_b)    : 32'(go_s);
  assign o_stage = use_big ? 32'(stage_b) : 32'(stage_s);
  assign o_rd    = use_big ? 32'(rd_b)    : 32'(rd_s);
  assign o_wa    = use_big ? 32'(wa_b)    : 32'(wa_s);
  assign o_tw    = use_big ? 32'(tw_b)    : 32'(tw_s);
  int checks = 0, passed = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive_start(input logic v);
    if (use_big) start_b = v; else start_s = v;
  endtask
  function automatic int addr_of(int logn, int s, int j, int hi);
    int h = (1 << logn) >> (s + 1);
    int a = ((j >> (logn - 1 - s)) << (logn - s)) | (j & (h - 1));
    return hi != 0 ? a + h : a;
  endfunction
  function automatic int tw_of(int logn, int s, int j);
    int h = (1 << logn) >> (s + 1);
    return ((j & (h - 1)) << s) & ((1 << (logn - 1)) - 1);
  endfunction
  // Expected outputs k cycles after the cycle in which start was sampled.
  task automatic check_cycle(input int logn, input int lat, input int k);
    int n = 1 << logn;
    int per = n + lat + 2;
    int s = (k >= 1) ? (k - 1) / per : 0;
    int r = (k >= 1) ? (k - 1) % per : 0;
    int w = r - lat - 2;
    bit act = (k >= 1) && (s < logn);
    bit go = act && r >= 2 && r <= n && r % 2 == 0;
    bit we = act && w >= 0 && w < n;
    chk("busy", o_busy, 32'(act));
    chk("done", o_done, 32'(k == logn * per + 1));
    chk("bf_ld_a", o_ld, 32'(act && r < n && r % 2 == 1));
    chk("bf_go", o_go, 32'(go));
    chk("wr_en", o_we, 32'(we));
    if (act) chk("stage", o_stage, 32'(s));
    if (act && r < n) chk("rd_addr", o_rd, 32'(addr_of(logn, s, r / 2, r % 2)));
    if (go) chk("tw_idx", o_tw, 32'(tw_of(logn, s, (r - 2) / 2)));
    if (we) begin
      chk("wr_addr", o_wa, 32'(addr_of(logn, s, w / 2, w % 2)));
      chk("wr_sel", o_sel, 32'(w % 2));
    end
  endtask
  task automatic run(input int logn, input int lat, input bit rnd);
    int last = logn * ((1 << logn) + lat + 2) + 2;
    int nwr = 0;
    drive_start(1'b1);
    check_cycle(logn, lat, 0);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      drive_start((rnd && k < last) ? 1'($urandom % 2) : 1'b0);
      check_cycle(logn, lat, k);
      nwr += int'(o_we);
    end
    chk("write_count", 32'(nwr), 32'(logn * (1 << logn)));
  endtask
  task automatic check_quiet(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      chk("quiet_busy", o_busy, 0);
      chk("quiet_wr_en", o_we, 0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      use_big = 1'(d);
      #0;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_stage", o_stage, 0);
      chk("rst_rd_addr", o_rd, 0);
      chk("rst_wr_en", o_we, 0);
      chk("rst_wr_addr", o_wa, 0);
      chk("rst_wr_sel", o_sel, 0);
      chk("rst_bf_ld_a", o_ld, 0);
      chk("rst_bf_go", o_go, 0);
      chk("rst_tw_idx", o_tw, 0);
    end
    use_big = 1'b0;
    rst = 1'b0;
    check_quiet(20);
    run(3, 2, 1'b1);
    check_quiet(5);
    drive_start(1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      drive_start(1'b0);
      check_cycle(3, 2, k);
    end
    rst = 1'b1;
    #1;
    chk("abort_wr_en", o_we, 0);
    chk("abort_busy", o_busy, 0);
    @(posedge clk);
    #1;
    chk("abort_hold_wr_en", o_we, 0);
    rst = 1'b0;
    check_quiet(30);
    run(3, 2, 1'b0);
    use_big = 1'b1;
    #1;
    run(11, 4, 1'b1);
    check_quiet(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
